// File: rtl/dcache_drv_pkg.sv
// Shared definitions for the D$ port driver.
//
// Holds the driver FSM state type, the registered command record, the lane
// width, the cache-port request/response types and a small alignment helper.
// The physical address width and the index/tag split mirror the ariane_pkg
// values of the cache-only unit-test configuration:
//   PLEN = 56, DCACHE_INDEX_WIDTH = 12, DCACHE_TAG_WIDTH = 44.
// Keeping them here lets the driver build standalone in the unit-test slice.
package dcache_drv_pkg;

  localparam int unsigned PLEN               = 56;
  localparam int unsigned DCACHE_INDEX_WIDTH = 12;
  localparam int unsigned DCACHE_TAG_WIDTH   = 44;
  localparam int unsigned LANE_W             = 64;
  localparam int unsigned LANE_BYTES         = LANE_W / 8;

  typedef enum logic [2:0] {
    DRV_IDLE    = 3'd0,
    DRV_REQ     = 3'd1,
    DRV_TAG     = 3'd2,
    DRV_WAIT_RD = 3'd3,
    DRV_RESP    = 3'd4
  } dcache_drv_state_e;

  typedef struct packed {
    logic              we;
    logic [PLEN-1:0]   addr;
    logic [1:0]        size;
    logic [LANE_W-1:0] wdata;
  } dcache_drv_cmd_t;

  // Request toward one D$ port (index phase followed by tag phase).
  typedef struct packed {
    logic [DCACHE_INDEX_WIDTH-1:0] address_index;
    logic [DCACHE_TAG_WIDTH-1:0]   address_tag;
    logic [LANE_W-1:0]             data_wdata;
    logic                          data_req;
    logic                          data_we;
    logic [LANE_BYTES-1:0]         data_be;
    logic [1:0]                    data_size;
    logic                          kill_req;
    logic                          tag_valid;
  } dcache_req_i_t;

  // Response from one D$ port.
  typedef struct packed {
    logic              data_gnt;
    logic              data_rvalid;
    logic [LANE_W-1:0] data_rdata;
  } dcache_req_o_t;

  // True when the byte offset is not a multiple of the access size.
  function automatic logic is_misaligned(input logic [2:0] off, input logic [1:0] size);
    logic [2:0] mask;
    case (size)
      2'd0:    mask = 3'b000;
      2'd1:    mask = 3'b001;
      2'd2:    mask = 3'b011;
      default: mask = 3'b111;
    endcase
    return |(off & mask);
  endfunction

endpackage

// File: rtl/dcache_lane_align.sv
// Combinational lane alignment for a 64-bit D$ data lane.
//
// Ports:
//   off      in  3   byte offset within the lane (addr[2:0])
//   size     in  2   access size: 0 byte, 1 half, 2 word, 3 double
//   wdata    in  64  right-aligned store data
//   rdata    in  64  raw lane data returned by the cache
//   be       out 8   byte enables placed at the offset
//   wdata_sh out 64  store data shifted up to the offset
//   rdata_sh out 64  load data shifted down to bit 0, zero-extended to size
module dcache_lane_align
  import dcache_drv_pkg::*;
(
  input  logic [2:0]            off,
  input  logic [1:0]            size,
  input  logic [LANE_W-1:0]     wdata,
  input  logic [LANE_W-1:0]     rdata,
  output logic [LANE_BYTES-1:0] be,
  output logic [LANE_W-1:0]     wdata_sh,
  output logic [LANE_W-1:0]     rdata_sh
);

  logic [LANE_BYTES-1:0] be_base_s;
  logic [LANE_W-1:0]     size_mask_s;
  logic [LANE_W-1:0]     rdata_down_s;

  // Decode the access size into a byte-enable seed and a data mask.
  always_comb begin
    case (size)
      2'd0: begin
        be_base_s   = 8'h01;
        size_mask_s = 64'h0000_0000_0000_00FF;
      end
      2'd1: begin
        be_base_s   = 8'h03;
        size_mask_s = 64'h0000_0000_0000_FFFF;
      end
      2'd2: begin
        be_base_s   = 8'h0F;
        size_mask_s = 64'h0000_0000_FFFF_FFFF;
      end
      default: begin
        be_base_s   = 8'hFF;
        size_mask_s = 64'hFFFF_FFFF_FFFF_FFFF;
      end
    endcase
  end

  // Shift enables/data to and from the byte offset.
  always_comb begin
    be           = be_base_s << off;
    wdata_sh     = wdata << {off, 3'b000};
    rdata_down_s = rdata >> {off, 3'b000};
    rdata_sh     = rdata_down_s & size_mask_s;
  end

endmodule

// File: rtl/dcache_port_driver.sv
// Command-to-port adapter driving one D$ request port.
//
// Accepts one load/store command at a time over valid/ready, runs the
// index (REQ) and tag (TAG) phases on the cache port, and returns a
// one-cycle response pulse carrying load data or store completion.
// All outputs are registered from the next-state decode, so they change
// only on clock edges and drop immediately on asynchronous reset.
//
// Parameters:
//   IsStorePort  1 = drives the store port (stores complete on gnt,
//                loads are rejected with an error)
//   GntTimeout   REQ cycles to wait for gnt before aborting
//                (only with DCACHE_PORT_DRIVER_TIMEOUT_EN defined)
// Ports:
//   clk_i, rst_ni                 clock, async active-low reset
//   cmd_valid_i / cmd_ready_o     command handshake
//   cmd_we_i, cmd_addr_i,
//   cmd_size_i, cmd_wdata_i       command fields
//   rsp_valid_o, rsp_rdata_o,
//   rsp_err_o                     response pulse
//   busy_o                        FSM not idle
//   dcache_req_o / dcache_rsp_i   cache port
// Configuration macro:
//   DCACHE_PORT_DRIVER_TIMEOUT_EN  enables the gnt timeout counter
module dcache_port_driver
  import dcache_drv_pkg::*;
#(
  parameter bit          IsStorePort = 1'b0,
  parameter int unsigned GntTimeout  = 256
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic              cmd_we_i,
  input  logic [PLEN-1:0]   cmd_addr_i,
  input  logic [1:0]        cmd_size_i,
  input  logic [LANE_W-1:0] cmd_wdata_i,
  output logic              rsp_valid_o,
  output logic [LANE_W-1:0] rsp_rdata_o,
  output logic              rsp_err_o,
  output logic              busy_o,
  output dcache_req_i_t     dcache_req_o,
  input  dcache_req_o_t     dcache_rsp_i
);

  dcache_drv_state_e state_r, state_next_s;
  dcache_drv_cmd_t   cmd_r, cmd_next_s;
  dcache_req_i_t     req_r, req_next_s;

  logic              ready_r, busy_r, rsp_valid_r, rsp_err_r;
  logic [LANE_W-1:0] rsp_rdata_r;

  logic              accept_s, illegal_s, timeout_s;
  logic              err_next_s, load_done_s;
  logic [LANE_W-1:0] rsp_rdata_next_s;

  logic [LANE_BYTES-1:0] be_s;
  logic [LANE_W-1:0]     wdata_sh_s, rdata_sh_s;

`ifdef DCACHE_PORT_DRIVER_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(GntTimeout + 1);

  logic [CntW-1:0] gnt_cnt_r;

  // Count REQ cycles; held at zero outside REQ so every REQ entry starts fresh.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      gnt_cnt_r <= '0;
    end else if (state_r != DRV_REQ) begin
      gnt_cnt_r <= '0;
    end else begin
      gnt_cnt_r <= gnt_cnt_r + CntW'(1);
    end
  end

  // Last allowed REQ cycle: leaving here keeps data_req high GntTimeout cycles.
  assign timeout_s = (state_r == DRV_REQ) && (gnt_cnt_r == CntW'(GntTimeout - 1));
`else
  logic unused_timeout_s;

  assign unused_timeout_s = ^GntTimeout;
  assign timeout_s        = 1'b0;
`endif

  // Accepted command is captured at the acceptance edge; otherwise held.
  always_comb begin
    accept_s  = cmd_valid_i && (state_r == DRV_IDLE);
    illegal_s = is_misaligned(cmd_addr_i[2:0], cmd_size_i) || (IsStorePort && !cmd_we_i);
    if (accept_s) begin
      cmd_next_s.we    = cmd_we_i;
      cmd_next_s.addr  = cmd_addr_i;
      cmd_next_s.size  = cmd_size_i;
      cmd_next_s.wdata = cmd_wdata_i;
    end else begin
      cmd_next_s = cmd_r;
    end
  end

  // Lane alignment works on the next command so the REQ outputs can be registered.
  dcache_lane_align u_lane_align (
    .off      (cmd_next_s.addr[2:0]),
    .size     (cmd_next_s.size),
    .wdata    (cmd_next_s.wdata),
    .rdata    (dcache_rsp_i.data_rdata),
    .be       (be_s),
    .wdata_sh (wdata_sh_s),
    .rdata_sh (rdata_sh_s)
  );

  // Next-state logic; also flags which RESP entries carry error or load data.
  always_comb begin
    state_next_s = state_r;
    err_next_s   = 1'b0;
    load_done_s  = 1'b0;
    case (state_r)
      DRV_IDLE: begin
        if (accept_s && illegal_s) begin
          state_next_s = DRV_RESP;
          err_next_s   = 1'b1;
        end else if (accept_s) begin
          state_next_s = DRV_REQ;
        end else begin
          state_next_s = DRV_IDLE;
        end
      end
      DRV_REQ: begin
        if (dcache_rsp_i.data_gnt) begin
          state_next_s = cmd_r.we ? DRV_RESP : DRV_TAG;
        end else if (timeout_s) begin
          state_next_s = DRV_RESP;
          err_next_s   = 1'b1;
        end else begin
          state_next_s = DRV_REQ;
        end
      end
      DRV_TAG, DRV_WAIT_RD: begin
        if (dcache_rsp_i.data_rvalid) begin
          state_next_s = DRV_RESP;
          load_done_s  = 1'b1;
        end else begin
          state_next_s = DRV_WAIT_RD;
        end
      end
      DRV_RESP: begin
        state_next_s = DRV_IDLE;
      end
      default: begin
        state_next_s = DRV_IDLE;
      end
    endcase
  end

  // Port request for the next state: index phase in REQ, tag phase in TAG.
  always_comb begin
    req_next_s = '0;
    if (state_next_s == DRV_REQ) begin
      req_next_s.data_req      = 1'b1;
      req_next_s.address_index = cmd_next_s.addr[DCACHE_INDEX_WIDTH-1:0];
      req_next_s.data_we       = cmd_next_s.we;
      req_next_s.data_size     = cmd_next_s.size;
      req_next_s.data_be       = be_s;
      req_next_s.data_wdata    = wdata_sh_s;
      // The store port has no separate tag phase, so the tag rides along here.
      if (cmd_next_s.we) begin
        req_next_s.address_tag = cmd_next_s.addr[DCACHE_INDEX_WIDTH +: DCACHE_TAG_WIDTH];
      end else begin
        req_next_s.address_tag = '0;
      end
    end else if (state_next_s == DRV_TAG) begin
      req_next_s.tag_valid   = 1'b1;
      req_next_s.address_tag = cmd_next_s.addr[DCACHE_INDEX_WIDTH +: DCACHE_TAG_WIDTH];
    end else begin
      req_next_s = '0;
    end
  end

  // Response data is only non-zero for a completed load.
  always_comb begin
    if (load_done_s) begin
      rsp_rdata_next_s = rdata_sh_s;
    end else begin
      rsp_rdata_next_s = '0;
    end
  end

  // State and command registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r <= DRV_IDLE;
      cmd_r   <= '0;
    end else begin
      state_r <= state_next_s;
      cmd_r   <= cmd_next_s;
    end
  end

  // Registered outputs decoded from the next state.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ready_r     <= 1'b1;
      busy_r      <= 1'b0;
      rsp_valid_r <= 1'b0;
      rsp_err_r   <= 1'b0;
      rsp_rdata_r <= '0;
      req_r       <= '0;
    end else begin
      ready_r     <= (state_next_s == DRV_IDLE);
      busy_r      <= (state_next_s != DRV_IDLE);
      rsp_valid_r <= (state_next_s == DRV_RESP);
      rsp_err_r   <= err_next_s;
      rsp_rdata_r <= rsp_rdata_next_s;
      req_r       <= req_next_s;
    end
  end

  assign cmd_ready_o  = ready_r;
  assign busy_o       = busy_r;
  assign rsp_valid_o  = rsp_valid_r;
  assign rsp_err_o    = rsp_err_r;
  assign rsp_rdata_o  = rsp_rdata_r;
  assign dcache_req_o = req_r;

endmodule

// File: tb/tb_dcache_port_driver.sv
// Directed bench for dcache_port_driver: one load-port and one store-port
// instance, each driven with hand-computed vectors. Inputs change 1 ns after
// the rising edge and outputs are sampled at the same point.
module tb_dcache_port_driver;
  import dcache_drv_pkg::*;

  logic clk_s;
  logic rst_n_s;

  // Load-port instance signals
  logic              ld_valid_s, ld_ready_s, ld_we_s, ld_rsp_valid_s, ld_err_s, ld_busy_s;
  logic [PLEN-1:0]   ld_addr_s;
  logic [1:0]        ld_size_s;
  logic [LANE_W-1:0] ld_wdata_s, ld_rdata_s;
  dcache_req_i_t     ld_req_s;
  dcache_req_o_t     ld_rsp_s;

  // Store-port instance signals
  logic              st_valid_s, st_ready_s, st_we_s, st_rsp_valid_s, st_err_s, st_busy_s;
  logic [PLEN-1:0]   st_addr_s;
  logic [1:0]        st_size_s;
  logic [LANE_W-1:0] st_wdata_s, st_rdata_s;
  dcache_req_i_t     st_req_s;
  dcache_req_o_t     st_rsp_s;

  int n_cmp_s;
  int n_err_s;

  dcache_port_driver #(.IsStorePort(1'b0), .GntTimeout(4)) u_ld (
    .clk_i        (clk_s),
    .rst_ni       (rst_n_s),
    .cmd_valid_i  (ld_valid_s),
    .cmd_ready_o  (ld_ready_s),
    .cmd_we_i     (ld_we_s),
    .cmd_addr_i   (ld_addr_s),
    .cmd_size_i   (ld_size_s),
    .cmd_wdata_i  (ld_wdata_s),
    .rsp_valid_o  (ld_rsp_valid_s),
    .rsp_rdata_o  (ld_rdata_s),
    .rsp_err_o    (ld_err_s),
    .busy_o       (ld_busy_s),
    .dcache_req_o (ld_req_s),
    .dcache_rsp_i (ld_rsp_s)
  );

  dcache_port_driver #(.IsStorePort(1'b1), .GntTimeout(4)) u_st (
    .clk_i        (clk_s),
    .rst_ni       (rst_n_s),
    .cmd_valid_i  (st_valid_s),
    .cmd_ready_o  (st_ready_s),
    .cmd_we_i     (st_we_s),
    .cmd_addr_i   (st_addr_s),
    .cmd_size_i   (st_size_s),
    .cmd_wdata_i  (st_wdata_s),
    .rsp_valid_o  (st_rsp_valid_s),
    .rsp_rdata_o  (st_rdata_s),
    .rsp_err_o    (st_err_s),
    .busy_o       (st_busy_s),
    .dcache_req_o (st_req_s),
    .dcache_rsp_i (st_rsp_s)
  );

  // 100 MHz clock
  initial begin
    clk_s = 1'b0;
    forever #5 clk_s = ~clk_s;
  end

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp_s++;
    if (obs !== exp) begin
      n_err_s++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_s);
    #1;
  endtask

  // Present a command on the load port and step through the acceptance edge.
  task automatic ld_cmd(input logic we, input logic [PLEN-1:0] addr, input logic [1:0] size);
    ld_valid_s = 1'b1;
    ld_we_s    = we;
    ld_addr_s  = addr;
    ld_size_s  = size;
    ld_wdata_s = 64'd0;
    tick();
    ld_valid_s = 1'b0;
  endtask

  task automatic st_cmd(input logic we, input logic [PLEN-1:0] addr, input logic [1:0] size,
                        input logic [63:0] wdata);
    st_valid_s = 1'b1;
    st_we_s    = we;
    st_addr_s  = addr;
    st_size_s  = size;
    st_wdata_s = wdata;
    tick();
    st_valid_s = 1'b0;
  endtask

  initial begin
    int req_cycles;
    logic got_rsp;
    logic got_err;

    n_cmp_s    = 0;
    n_err_s    = 0;
    rst_n_s    = 1'b0;
    ld_valid_s = 1'b0; ld_we_s = 1'b0; ld_addr_s = '0; ld_size_s = 2'd0; ld_wdata_s = 64'd0;
    st_valid_s = 1'b0; st_we_s = 1'b0; st_addr_s = '0; st_size_s = 2'd0; st_wdata_s = 64'd0;
    ld_rsp_s   = '0;
    st_rsp_s   = '0;

    // Reset state
    tick();
    check_eq("rst_ready", 64'(ld_ready_s), 64'd1);
    check_eq("rst_rsp_valid", 64'(ld_rsp_valid_s), 64'd0);
    check_eq("rst_busy", 64'(ld_busy_s), 64'd0);
    check_eq("rst_req_zero", 64'(ld_req_s != '0), 64'd0);
    tick();
    rst_n_s = 1'b1;
    tick();

    // Stray rvalid while idle is ignored
    ld_rsp_s.data_rvalid = 1'b1;
    tick();
    ld_rsp_s.data_rvalid = 1'b0;
    check_eq("stray_rvalid", 64'(ld_rsp_valid_s), 64'd0);

    // Load double at 0x8000_0040, gnt immediate, rdata in the cycle after TAG
    ld_cmd(1'b0, 56'h0000_0080_0000_40, 2'd3);
    check_eq("ld_d_req", 64'(ld_req_s.data_req), 64'd1);
    check_eq("ld_d_index", 64'(ld_req_s.address_index), 64'h040);
    check_eq("ld_d_be", 64'(ld_req_s.data_be), 64'hFF);
    check_eq("ld_d_busy", 64'(ld_busy_s), 64'd1);
    ld_rsp_s.data_gnt = 1'b1;
    tick();
    ld_rsp_s.data_gnt = 1'b0;
    check_eq("ld_d_tag_valid", 64'(ld_req_s.tag_valid), 64'd1);
    check_eq("ld_d_tag", 64'(ld_req_s.address_tag), 64'h8_0000);
    check_eq("ld_d_req_in_tag", 64'(ld_req_s.data_req), 64'd0);
    tick();
    check_eq("ld_d_wait_tag_drop", 64'(ld_req_s.tag_valid), 64'd0);
    ld_rsp_s.data_rvalid = 1'b1;
    ld_rsp_s.data_rdata  = 64'h1122_3344_5566_7788;
    tick();
    ld_rsp_s.data_rvalid = 1'b0;
    check_eq("ld_d_rsp_valid", 64'(ld_rsp_valid_s), 64'd1);
    check_eq("ld_d_rdata", ld_rdata_s, 64'h1122_3344_5566_7788);
    check_eq("ld_d_err", 64'(ld_err_s), 64'd0);
    tick();
    check_eq("ld_d_pulse_end", 64'(ld_rsp_valid_s), 64'd0);
    check_eq("ld_d_ready_back", 64'(ld_ready_s), 64'd1);

    // Load half at 0x8000_0006, rvalid in the TAG cycle
    ld_cmd(1'b0, 56'h0000_0080_0000_06, 2'd1);
    check_eq("ld_h_be", 64'(ld_req_s.data_be), 64'hC0);
    ld_rsp_s.data_gnt = 1'b1;
    tick();
    ld_rsp_s.data_gnt    = 1'b0;
    ld_rsp_s.data_rvalid = 1'b1;
    ld_rsp_s.data_rdata  = 64'hBEEF_0000_0000_0000;
    tick();
    ld_rsp_s.data_rvalid = 1'b0;
    check_eq("ld_h_rsp_valid", 64'(ld_rsp_valid_s), 64'd1);
    check_eq("ld_h_rdata", ld_rdata_s, 64'h0000_0000_0000_BEEF);
    tick();

    // Misaligned load word at 0x8000_0002
    ld_cmd(1'b0, 56'h0000_0080_0000_02, 2'd2);
    check_eq("mis_rsp_valid", 64'(ld_rsp_valid_s), 64'd1);
    check_eq("mis_err", 64'(ld_err_s), 64'd1);
    check_eq("mis_no_req", 64'(ld_req_s.data_req), 64'd0);
    check_eq("mis_rdata", ld_rdata_s, 64'd0);
    tick();
    check_eq("mis_no_req_after", 64'(ld_req_s.data_req), 64'd0);
    check_eq("mis_ready", 64'(ld_ready_s), 64'd1);

    // Store byte 0xAB at 0x8000_0003, gnt in the first REQ cycle
    st_cmd(1'b1, 56'h0000_0080_0000_03, 2'd0, 64'hAB);
    check_eq("st_b_req", 64'(st_req_s.data_req), 64'd1);
    check_eq("st_b_be", 64'(st_req_s.data_be), 64'h08);
    check_eq("st_b_wdata", st_req_s.data_wdata, 64'hAB00_0000);
    check_eq("st_b_we", 64'(st_req_s.data_we), 64'd1);
    check_eq("st_b_tag", 64'(st_req_s.address_tag), 64'h8_0000);
    check_eq("st_b_no_rsp_yet", 64'(st_rsp_valid_s), 64'd0);
    st_rsp_s.data_gnt = 1'b1;
    tick();
    st_rsp_s.data_gnt = 1'b0;
    check_eq("st_b_rsp_valid", 64'(st_rsp_valid_s), 64'd1);
    check_eq("st_b_err", 64'(st_err_s), 64'd0);
    check_eq("st_b_req_drop", 64'(st_req_s.data_req), 64'd0);
    tick();

    // Store word at 0x8000_0004 with gnt withheld for two cycles
    st_cmd(1'b1, 56'h0000_0080_0000_04, 2'd2, 64'hDEAD_BEEF);
    check_eq("st_w_be", 64'(st_req_s.data_be), 64'hF0);
    tick();
    tick();
    check_eq("st_w_hold_req", 64'(st_req_s.data_req), 64'd1);
    check_eq("st_w_hold_wdata", st_req_s.data_wdata, 64'hDEAD_BEEF_0000_0000);
    st_rsp_s.data_gnt = 1'b1;
    tick();
    st_rsp_s.data_gnt = 1'b0;
    check_eq("st_w_rsp_valid", 64'(st_rsp_valid_s), 64'd1);
    tick();

    // Load on the store port is rejected
    st_cmd(1'b0, 56'h0000_0080_0000_00, 2'd3, 64'd0);
    check_eq("st_ld_err", 64'(st_err_s), 64'd1);
    check_eq("st_ld_no_req", 64'(st_req_s.data_req), 64'd0);
    tick();

`ifdef DCACHE_PORT_DRIVER_TIMEOUT_EN
    // gnt never arrives: data_req held for GntTimeout cycles, then error
    ld_cmd(1'b0, 56'h0000_0080_0000_10, 2'd2);
    req_cycles = 0;
    got_rsp    = 1'b0;
    got_err    = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (ld_rsp_valid_s) begin
        got_rsp = 1'b1;
        got_err = ld_err_s;
        break;
      end
      if (ld_req_s.data_req) req_cycles++;
      tick();
    end
    check_eq("to_req_cycles", 64'(req_cycles), 64'd4);
    check_eq("to_rsp_seen", 64'(got_rsp), 64'd1);
    check_eq("to_err", 64'(got_err), 64'd1);
    tick();
`else
    // Without the timeout, REQ waits for gnt indefinitely
    ld_cmd(1'b0, 56'h0000_0080_0000_10, 2'd2);
    req_cycles = 0;
    got_rsp    = 1'b0;
    got_err    = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (ld_req_s.data_req) req_cycles++;
      if (ld_rsp_valid_s) got_rsp = 1'b1;
      tick();
    end
    check_eq("wait_req_cycles", 64'(req_cycles), 64'd8);
    check_eq("wait_no_rsp", 64'(got_rsp), 64'd0);
    check_eq("wait_no_err", 64'(got_err), 64'd0);
    ld_rsp_s.data_gnt = 1'b1;
    tick();
    ld_rsp_s.data_gnt    = 1'b0;
    ld_rsp_s.data_rvalid = 1'b1;
    ld_rsp_s.data_rdata  = 64'h0000_0000_CAFE_F00D;
    tick();
    ld_rsp_s.data_rvalid = 1'b0;
    check_eq("wait_rdata", ld_rdata_s, 64'h0000_0000_CAFE_F00D);
    tick();
`endif

    // Reset asserted during WAIT_RD
    ld_cmd(1'b0, 56'h0000_0080_0000_80, 2'd3);
    ld_rsp_s.data_gnt = 1'b1;
    tick();
    ld_rsp_s.data_gnt = 1'b0;
    tick();
    check_eq("rst_mid_busy", 64'(ld_busy_s), 64'd1);
    check_eq("rst_mid_not_ready", 64'(ld_ready_s), 64'd0);
    #2;
    rst_n_s = 1'b0;
    #1;
    check_eq("rst_mid_busy_drop", 64'(ld_busy_s), 64'd0);
    check_eq("rst_mid_req_zero", 64'(ld_req_s != '0), 64'd0);
    check_eq("rst_mid_rsp_valid", 64'(ld_rsp_valid_s), 64'd0);
    check_eq("rst_mid_err", 64'(ld_err_s), 64'd0);
    check_eq("rst_mid_rdata", ld_rdata_s, 64'd0);
    ld_rsp_s = '0;
    tick();
    rst_n_s = 1'b1;
    tick();
    check_eq("rst_mid_ready_after", 64'(ld_ready_s), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp_s, n_err_s);
    $finish;
  end

endmodule
